// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt controller: CSR file (mstatus/mie/mtvec/mepc/mcause/mip),
// fixed-priority arbitration and a three-state trap handshake with the pipeline.
module irq_trap_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_irq,
  input  logic        sw_irq,
  input  logic        ext_irq,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic [31:0] pc_in,
  output logic        trap_req,
  input  logic        trap_ack,
  output logic [31:0] trap_vec,
  input  logic        mret_valid,
  output logic [31:0] ret_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [3:0] CAUSE_SW    = 4'd3;
  localparam logic [3:0] CAUSE_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_EXT   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACTIVE
  } state_e;

  state_e      state_q, state_d;
  logic        trap_req_q, trap_req_d;
  logic [3:0]  cause_q, cause_d;
  logic        mstat_mie_q, mstat_mie_d;
  logic        mstat_mpie_q, mstat_mpie_d;
  // Enable bits packed as {MEIE, MTIE, MSIE}.
  logic [2:0]  mie_en_q, mie_en_d;
  logic [31:2] mtvec_q, mtvec_d;
  logic [31:2] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic        pend_sw, pend_timer, pend_ext, any_pend;
  logic        cause_pend;
  logic [3:0]  win_cause;
  logic [31:0] mip_val;

  assign mip_val    = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, sw_irq, 3'b0};
  assign pend_sw    = sw_irq    & mie_en_q[0] & mstat_mie_q;
  assign pend_timer = timer_irq & mie_en_q[1] & mstat_mie_q;
  assign pend_ext   = ext_irq   & mie_en_q[2] & mstat_mie_q;
  assign any_pend   = pend_sw | pend_timer | pend_ext;

  always_comb begin
    win_cause = CAUSE_TIMER;
    if (pend_ext)     win_cause = CAUSE_EXT;
    else if (pend_sw) win_cause = CAUSE_SW;
  end

  // Re-check only the latched source; a newer higher-priority source must not retarget it.
  always_comb begin
    cause_pend = 1'b0;
    case (cause_q)
      CAUSE_EXT:   cause_pend = pend_ext;
      CAUSE_SW:    cause_pend = pend_sw;
      CAUSE_TIMER: cause_pend = pend_timer;
      default:     cause_pend = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the
    // case statements leaves it unassigned and infers a latch.
    state_d      = state_q;
    trap_req_d   = trap_req_q;
    cause_d      = cause_q;
    mstat_mie_d  = mstat_mie_q;
    mstat_mpie_d = mstat_mpie_q;
    mie_en_d     = mie_en_q;
    mtvec_d      = mtvec_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;

    if (csr_we) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mstat_mie_d  = csr_wdata[3];
          mstat_mpie_d = csr_wdata[7];
        end
        ADDR_MIE:    mie_en_d = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
        ADDR_MTVEC:  mtvec_d  = csr_wdata[31:2];
        ADDR_MEPC:   mepc_d   = csr_wdata[31:2];
        ADDR_MCAUSE: mcause_d = csr_wdata;
        default: ;
      endcase
    end

    // Hardware updates are applied after the software write so they take precedence.
    case (state_q)
      ST_IDLE: begin
        if (mret_valid) begin
          mstat_mie_d  = mstat_mpie_q;
          mstat_mpie_d = 1'b1;
        end
        if (any_pend) begin
          state_d    = ST_REQ;
          trap_req_d = 1'b1;
          cause_d    = win_cause;
        end
      end
      ST_REQ: begin
        if (trap_ack) begin
          mepc_d       = pc_in[31:2];
          mcause_d     = {1'b1, 27'b0, cause_q};
          mstat_mpie_d = mstat_mie_q;
          mstat_mie_d  = 1'b0;
          trap_req_d   = 1'b0;
          state_d      = ST_ACTIVE;
        end else if (!cause_pend) begin
          trap_req_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (mret_valid) begin
          mstat_mie_d  = mstat_mpie_q;
          mstat_mpie_d = 1'b1;
          state_d      = ST_IDLE;
        end
        if (any_pend) begin
          state_d    = ST_REQ;
          trap_req_d = 1'b1;
          cause_d    = win_cause;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        trap_req_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      trap_req_q   <= 1'b0;
      cause_q      <= '0;
      mstat_mie_q  <= 1'b0;
      mstat_mpie_q <= 1'b0;
      mie_en_q     <= '0;
      mtvec_q      <= MTVEC_RESET[31:2];
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else begin
      state_q      <= state_d;
      trap_req_q   <= trap_req_d;
      cause_q      <= cause_d;
      mstat_mie_q  <= mstat_mie_d;
      mstat_mpie_q <= mstat_mpie_d;
      mie_en_q     <= mie_en_d;
      mtvec_q      <= mtvec_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {24'b0, mstat_mpie_q, 3'b0, mstat_mie_q, 3'b0};
      ADDR_MIE:     csr_rdata = {20'b0, mie_en_q[2], 3'b0, mie_en_q[1], 3'b0, mie_en_q[0], 3'b0};
      ADDR_MTVEC:   csr_rdata = {mtvec_q, 2'b00};
      ADDR_MEPC:    csr_rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE:  csr_rdata = mcause_q;
      ADDR_MIP:     csr_rdata = mip_val;
      default:      csr_rdata = '0;
    endcase
  end

  assign trap_req = trap_req_q;
  assign trap_vec = {mtvec_q, 2'b00};
  assign ret_pc   = {mepc_q, 2'b00};

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: CSR vector table plus hand-written
// trap/withdraw/mret/reset sequences, with CSR readbacks checked via a scoreboard queue.
module tb_irq_trap_ctrl;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_irq, sw_irq, ext_irq;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] pc_in;
  logic        trap_req;
  logic        trap_ack;
  logic [31:0] trap_vec;
  logic        mret_valid;
  logic [31:0] ret_pc;

  irq_trap_ctrl #(.MTVEC_RESET(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .timer_irq(timer_irq), .sw_irq(sw_irq), .ext_irq(ext_irq),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .pc_in(pc_in), .trap_req(trap_req), .trap_ack(trap_ack), .trap_vec(trap_vec),
    .mret_valid(mret_valid), .ret_pc(ret_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic expect_rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    sb.push_back('{name, addr, exp});
  endtask

  // Pops queued readbacks; each read takes 1 ns, so callers keep drains short between edges.
  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      csr_addr = e.addr;
      #1;
      check(e.name, csr_rdata, e.exp);
    end
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    @(posedge clk);
    #1;
    csr_we    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (trap_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, trap_req}, 32'd1);
  endtask

  task automatic take(input logic [31:0] pc);
    trap_ack = 1'b1;
    pc_in    = pc;
    @(posedge clk);
    #1;
    trap_ack = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"tbl_mtvec_align",   A_MTVEC,   32'h0000_1237, 32'h0000_1234};
    vecs[1] = '{"tbl_mepc_align",    A_MEPC,    32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[2] = '{"tbl_mcause_full",   A_MCAUSE,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{"tbl_mstatus_mask",  A_MSTATUS, 32'hFFFF_FFFF, 32'h0000_0088};
    vecs[4] = '{"tbl_mstatus_clr",   A_MSTATUS, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{"tbl_mie_mask",      A_MIE,     32'hFFFF_FFFF, 32'h0000_0888};
    vecs[6] = '{"tbl_mie_clr",       A_MIE,     32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{"tbl_mip_readonly",  A_MIP,     32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{"tbl_unmapped",      12'h123,   32'hFFFF_FFFF, 32'h0000_0000};

    rst = 1'b1;
    timer_irq = 1'b0; sw_irq = 1'b0; ext_irq = 1'b0;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    pc_in = '0; trap_ack = 1'b0; mret_valid = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_trap_req", {31'b0, trap_req}, 32'd0);
    check("rst_trap_vec", trap_vec, 32'h0000_0100);
    expect_rd("rst_mstatus", A_MSTATUS, 32'h0);
    expect_rd("rst_mie",     A_MIE,     32'h0);
    expect_rd("rst_mepc",    A_MEPC,    32'h0);
    expect_rd("rst_mcause",  A_MCAUSE,  32'h0);
    expect_rd("rst_mtvec",   A_MTVEC,   32'h0000_0100);
    drain();
    @(negedge clk);
    rst = 1'b0;

    // CSR vector table
    for (int i = 0; i < 9; i++) begin
      csr_write(vecs[i].addr, vecs[i].wdata);
      expect_rd(vecs[i].name, vecs[i].addr, vecs[i].exp);
      @(negedge clk);
      drain();
    end
    check("tbl_ret_pc", ret_pc, 32'hFFFF_FFFC);

    // Basic timer take, then MRET re-request, then withdrawal
    do_reset();
    csr_write(A_MIE, 32'h80);
    csr_write(A_MSTATUS, 32'h8);
    timer_irq = 1'b1;
    @(negedge clk);
    check("take_lat_before_edge", {31'b0, trap_req}, 32'd0);
    @(negedge clk);
    check("take_lat_one_cycle", {31'b0, trap_req}, 32'd1);
    take(32'h0000_2004);
    @(negedge clk);
    check("take_req_dropped", {31'b0, trap_req}, 32'd0);
    check("take_trap_vec", trap_vec, 32'h0000_0100);
    expect_rd("take_mepc",    A_MEPC,    32'h0000_2004);
    expect_rd("take_mcause",  A_MCAUSE,  32'h8000_0007);
    expect_rd("take_mstatus", A_MSTATUS, 32'h0000_0080);
    drain();
    @(negedge clk);
    check("active_no_retake", {31'b0, trap_req}, 32'd0);
    mret_valid = 1'b1;
    @(posedge clk);
    #1;
    mret_valid = 1'b0;
    @(negedge clk);
    check("mret_no_req_yet", {31'b0, trap_req}, 32'd0);
    expect_rd("mret_mstatus", A_MSTATUS, 32'h0000_0088);
    drain();
    @(negedge clk);
    check("mret_rereq", {31'b0, trap_req}, 32'd1);
    timer_irq = 1'b0;
    @(negedge clk);
    check("withdraw_req", {31'b0, trap_req}, 32'd0);
    expect_rd("withdraw_mepc",   A_MEPC,   32'h0000_2004);
    expect_rd("withdraw_mcause", A_MCAUSE, 32'h8000_0007);
    drain();
    @(negedge clk);
    check("withdraw_stays_idle", {31'b0, trap_req}, 32'd0);

    // Priority with simultaneous sources; CSR write to mcause during ack loses
    do_reset();
    csr_write(A_MIE, 32'h888);
    csr_write(A_MSTATUS, 32'h8);
    timer_irq = 1'b1; sw_irq = 1'b1; ext_irq = 1'b1;
    wait_req("prio_req");
    csr_we = 1'b1; csr_addr = A_MCAUSE; csr_wdata = 32'h1234_5678;
    take(32'h0000_3000);
    csr_we = 1'b0;
    timer_irq = 1'b0; sw_irq = 1'b0; ext_irq = 1'b0;
    @(negedge clk);
    expect_rd("prio_mcause", A_MCAUSE, 32'h8000_000B);
    expect_rd("prio_mepc",   A_MEPC,   32'h0000_3000);
    drain();

    // Latched cause kept when a higher source arrives; ack beats same-cycle mret
    do_reset();
    csr_write(A_MIE, 32'h888);
    csr_write(A_MSTATUS, 32'h88);
    sw_irq = 1'b1;
    wait_req("latch_req");
    ext_irq = 1'b1;
    @(negedge clk);
    check("latch_req_held", {31'b0, trap_req}, 32'd1);
    mret_valid = 1'b1;
    take(32'h0000_4006);
    mret_valid = 1'b0;
    @(negedge clk);
    check("latch_active", {31'b0, trap_req}, 32'd0);
    expect_rd("latch_mcause",  A_MCAUSE,  32'h8000_0003);
    expect_rd("ack_vs_mret",   A_MSTATUS, 32'h0000_0080);
    expect_rd("latch_mepc",    A_MEPC,    32'h0000_4004);
    drain();
    // Ack outside REQ is ignored
    take(32'h0000_9000);
    @(negedge clk);
    check("ack_not_req_ret_pc", ret_pc, 32'h0000_4004);
    sw_irq = 1'b0; ext_irq = 1'b0;

    // Masking by MTIE and by MIE
    do_reset();
    csr_write(A_MSTATUS, 32'h8);
    timer_irq = 1'b1;
    repeat (3) @(negedge clk);
    check("mask_mtie", {31'b0, trap_req}, 32'd0);
    expect_rd("mask_mip", A_MIP, 32'h0000_0080);
    drain();
    csr_write(A_MSTATUS, 32'h0);
    csr_write(A_MIE, 32'h80);
    repeat (3) @(negedge clk);
    check("mask_mie", {31'b0, trap_req}, 32'd0);

    // mret in REQ ignored, then nested take after software re-enables MIE
    csr_write(A_MTVEC, 32'h0000_2000);
    csr_write(A_MSTATUS, 32'h8);
    wait_req("req_for_mret");
    mret_valid = 1'b1;
    @(posedge clk);
    #1;
    mret_valid = 1'b0;
    @(negedge clk);
    check("mret_in_req_req", {31'b0, trap_req}, 32'd1);
    expect_rd("mret_in_req_mstatus", A_MSTATUS, 32'h0000_0008);
    drain();
    @(negedge clk);
    take(32'h0000_0500);
    repeat (2) @(negedge clk);
    check("nest_masked", {31'b0, trap_req}, 32'd0);
    csr_write(A_MSTATUS, 32'h88);
    wait_req("nest_req");
    check("nest_trap_vec", trap_vec, 32'h0000_2000);

    // Asynchronous reset between edges while in REQ
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'b0, trap_req}, 32'd0);
    check("async_rst_vec", trap_vec, 32'h0000_0100);
    expect_rd("async_mstatus", A_MSTATUS, 32'h0);
    expect_rd("async_mie",     A_MIE,     32'h0);
    expect_rd("async_mepc",    A_MEPC,    32'h0);
    expect_rd("async_mcause",  A_MCAUSE,  32'h0);
    expect_rd("async_mtvec",   A_MTVEC,   32'h0000_0100);
    drain();
    timer_irq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {31'b0, trap_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_trap_ctrl.md
IRQ_TRAP_CTRL -- requirements
Module: irq_trap_ctrl

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0100, reset value of mtvec.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port timer_irq  in  1  level machine-timer interrupt (mtime >= mtimecmp), cause 7.
REQ-005 SHALL have port sw_irq  in  1  level machine-software interrupt, cause 3.
REQ-006 SHALL have port ext_irq  in  1  level machine-external interrupt, cause 11.
REQ-007 SHALL have port csr_we  in  1  CSR write strobe.
REQ-008 SHALL have port csr_addr  in  12  CSR address, for both read and write.
REQ-009 SHALL have port csr_wdata  in  32  CSR write data.
REQ-010 SHALL have port csr_rdata  out  32  combinational read of csr_addr; unmapped addresses read 0.
REQ-011 SHALL have port pc_in  in  32  PC of the oldest uncommitted instruction, sampled on trap_ack.
REQ-012 SHALL have port trap_req  out  1  registered interrupt-take request to the pipeline.
REQ-013 SHALL have port trap_ack  in  1  pipeline accepts the trap this cycle.
REQ-014 SHALL have port trap_vec  out  32  equals mtvec.
REQ-015 SHALL have port mret_valid  in  1  one-cycle MRET commit pulse.
REQ-016 SHALL have port ret_pc  out  32  equals mepc.

Function
REQ-017 SHALL implement these CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0); mie 0x304 (MSIE bit3, MTIE bit7, MEIE bit11); mtvec 0x305; mepc 0x341; mcause 0x342; mip 0x344.
REQ-018 mip SHALL be read-only, with MSIP=sw_irq, MTIP=timer_irq, MEIP=ext_irq, all live; writes to mip are ignored.
REQ-019 mtvec and mepc SHALL be direct-mode only, with bits[1:0] forced to 0 on write and on read.
REQ-020 Software writes to mcause SHALL store all 32 bits.
REQ-021 An interrupt SHALL be pending-enabled when mip bit & mie bit & mstatus.MIE are all 1.
REQ-022 Priority SHALL be fixed: ext (11) > sw (3) > timer (7).
REQ-023 The FSM SHALL have 3 states: IDLE, REQ, ACTIVE.
REQ-024 In IDLE, if any interrupt is pending-enabled at a clock edge, the FSM SHALL go to REQ, latch the winning cause code, and set trap_req=1 at that same edge.
REQ-025 Trap request latency SHALL be 1 cycle from source assertion.
REQ-026 In REQ, trap_req SHALL stay 1 until trap_ack, or until withdrawal.
REQ-027 On trap_ack in REQ: mepc <= pc_in & ~3; mcause <= {1'b1, 27'b0, cause}; MPIE <= MIE; MIE <= 0; trap_req <= 0; state <= ACTIVE.
REQ-028 Withdrawal SHALL occur when, in REQ without trap_ack, the latched cause is no longer pending-enabled (source dropped, mie bit cleared, or MIE cleared): trap_req <= 0 and state <= IDLE; re-arbitration happens from IDLE on the next edge.
REQ-029 A higher-priority source arriving in REQ SHALL NOT change the latched cause.
REQ-030 On mret_valid: MIE <= MPIE; MPIE <= 1; state <= IDLE if in ACTIVE. The same update SHALL apply in IDLE.
REQ-031 mret_valid in REQ SHALL be ignored.
REQ-032 When trap_ack and a CSR write to mstatus/mepc/mcause occur in the same cycle, the hardware trap update SHALL win; the CSR write is dropped for those registers only.
REQ-033 When trap_ack and mret_valid occur in the same cycle, trap_ack SHALL win and mret_valid is ignored.
REQ-034 trap_ack while not in REQ SHALL be ignored.
REQ-035 In ACTIVE, new interrupts SHALL be taken only after software sets MIE=1; the FSM then goes to REQ by the same rule as IDLE, which supports nesting.

Reset
REQ-036 While rst=1, regardless of clock: state=IDLE, trap_req=0, MIE=0, MPIE=0, mie=0, mepc=0, mcause=0, mtvec=MTVEC_RESET.
REQ-037 Reset asserted in REQ or ACTIVE SHALL drop trap_req immediately (asynchronous), with no pending trap retained.

Verification
REQ-038 Basic timer take: mie=0x80, mstatus=0x8, raise timer_irq, ack with pc_in=0x0000_2004 -> trap_req high 1 cycle after raise; after ack, mepc=0x2004, mcause=0x8000_0007, mstatus=0x80, trap_vec=0x100.
REQ-039 Priority: timer_irq, sw_irq, and ext_irq all raised in the same cycle with all enabled -> mcause=0x8000_000B after ack.
REQ-040 Masking: timer_irq=1 with MTIE=0 or MIE=0 -> trap_req stays 0; mip reads 0x80.
REQ-041 Withdrawal: timer_irq drops while in REQ before ack -> trap_req 0 next cycle; mepc and mcause unchanged.
REQ-042 MRET: after a take, mret_valid pulse -> mstatus=0x88, state IDLE; if timer_irq is still high, trap_req reasserts 1 cycle later.
REQ-043 Async reset: rst pulse mid-REQ, between clock edges -> trap_req falls immediately; mtvec=0x100, all other CSRs 0.
